// File: rtl/alu_issue_ctrl_if.sv
// Request/retire channel between decode and the ALU issue controller.
// master = requester, slave = alu_issue_ctrl.
interface alu_issue_ctrl_if #(
    parameter int REG_AW = 3
);
    logic              req_valid;
    logic              req_ready;
    logic [5:0]        req_opcode;
    logic [REG_AW-1:0] req_dst;
    logic [REG_AW-1:0] req_src_a;
    logic [REG_AW-1:0] req_src_b;
    logic              req_use_imm;
    logic [15:0]       req_imm;
    logic              done;
    logic [15:0]       done_result;
    logic              err_div0;

    modport master (
        output req_valid, req_opcode, req_dst,
        output req_src_a, req_src_b,
        output req_use_imm, req_imm,
        input  req_ready, done, done_result, err_div0
    );

    modport slave (
        input  req_valid, req_opcode, req_dst,
        input  req_src_a, req_src_b,
        input  req_use_imm, req_imm,
        output req_ready, done, done_result, err_div0
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: regfile, operand latch, ALU drive, writeback.
// Optional ALU_ISSUE_BYPASS_EN: accept in WB with result forwarding.
`ifndef ALU_NOP
`define ALU_NOP 6'h00
`define ALU_ADD 6'h01
`define ALU_SUB 6'h02
`define ALU_AND 6'h03
`define ALU_OR  6'h04
`define ALU_XOR 6'h05
`define ALU_NOT 6'h06
`define ALU_INC 6'h07
`define ALU_DEC 6'h08
`define ALU_SHL 6'h09
`define ALU_SHR 6'h0A
`define ALU_MUL 6'h0B
`define ALU_DIV 6'h0C
`define ALU_MOD 6'h0D
`define ALU_CMP 6'h0E
`define ALU_TST 6'h0F
`define ALU_MOV 6'h10
`endif

module alu_issue_ctrl #(
    parameter int NREGS  = 8,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_ctrl_if.slave   req,
    output logic [15:0]       alu_A,
    output logic [15:0]       alu_B,
    output logic [5:0]        alu_opcode,
    output logic              alu_enable,
    input  logic [15:0]       alu_Result,
    input  logic [3:0]        alu_flags,
    output logic [3:0]        flag_reg,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [15:0]       dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t            state;
    logic [15:0]       rf [NREGS];
    logic [REG_AW-1:0] dst_q;
    logic [15:0]       res_q;
    logic [3:0]        flg_q;
    logic              div0_q;
    logic              rdy_q;
    logic              done_q;
    logic              err_q;
    logic [15:0]       dres_q;

    logic              accept;
    logic              wb_reg;
    logic              wb_flg;
    logic              ex_div0;
    logic [5:0]        op_n;
    logic [15:0]       opa;
    logic [15:0]       opb;

    assign req.req_ready   = rdy_q;
    assign req.done        = done_q;
    assign req.done_result = dres_q;
    assign req.err_div0    = err_q;

    assign accept = req.req_valid && rdy_q;

    // Unknown opcodes are issued to the ALU as NOP.
    always_comb begin
        op_n = `ALU_NOP;
        case (req.req_opcode)
            `ALU_ADD, `ALU_SUB, `ALU_AND, `ALU_OR,
            `ALU_XOR, `ALU_NOT, `ALU_INC, `ALU_DEC,
            `ALU_SHL, `ALU_SHR, `ALU_MUL, `ALU_DIV,
            `ALU_MOD, `ALU_CMP, `ALU_TST, `ALU_MOV:
                op_n = req.req_opcode;
            default:
                op_n = `ALU_NOP;
        endcase
    end

    assign wb_reg = (state == WB) && !div0_q
                 && (alu_opcode != `ALU_CMP)
                 && (alu_opcode != `ALU_TST)
                 && (alu_opcode != `ALU_NOP)
                 && (dst_q != '0);

    assign wb_flg = (state == WB) && !div0_q
                 && (alu_opcode != `ALU_NOP);

    assign ex_div0 = ((alu_opcode == `ALU_DIV)
                   || (alu_opcode == `ALU_MOD))
                  && (alu_B == 16'h0000);

    always_comb begin
        opa = (req.req_src_a == '0) ? 16'h0 : rf[req.req_src_a];
        opb = (req.req_src_b == '0) ? 16'h0 : rf[req.req_src_b];
`ifdef ALU_ISSUE_BYPASS_EN
        // wb_reg already excludes dst 0, so R0 never forwards.
        if (wb_reg && (req.req_src_a == dst_q))
            opa = res_q;
        if (wb_reg && (req.req_src_b == dst_q))
            opb = res_q;
`endif
        if (req.req_use_imm)
            opb = req.req_imm;
    end

    assign dbg_data = (dbg_addr == '0) ? 16'h0 : rf[dbg_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                rf[i] <= 16'h0;
        end else if (wb_reg) begin
            rf[dst_q] <= res_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rdy_q      <= 1'b1;
            alu_A      <= 16'h0;
            alu_B      <= 16'h0;
            alu_opcode <= `ALU_NOP;
            alu_enable <= 1'b0;
            dst_q      <= '0;
            res_q      <= 16'h0;
            flg_q      <= 4'h0;
            div0_q     <= 1'b0;
            done_q     <= 1'b0;
            dres_q     <= 16'h0;
            err_q      <= 1'b0;
            flag_reg   <= 4'h0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        alu_A      <= opa;
                        alu_B      <= opb;
                        alu_opcode <= op_n;
                        dst_q      <= req.req_dst;
                        alu_enable <= 1'b1;
                        rdy_q      <= 1'b0;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    res_q      <= alu_Result;
                    flg_q      <= alu_flags;
                    div0_q     <= ex_div0;
                    done_q     <= 1'b1;
                    err_q      <= ex_div0;
                    dres_q     <= ex_div0 ? 16'hFFFF : alu_Result;
                    alu_enable <= 1'b0;
`ifdef ALU_ISSUE_BYPASS_EN
                    rdy_q      <= 1'b1;
`else
                    rdy_q      <= 1'b0;
`endif
                    state      <= WB;
                end
                WB: begin
                    if (wb_flg)
                        flag_reg <= flg_q;
`ifdef ALU_ISSUE_BYPASS_EN
                    if (accept) begin
                        alu_A      <= opa;
                        alu_B      <= opb;
                        alu_opcode <= op_n;
                        dst_q      <= req.req_dst;
                        alu_enable <= 1'b1;
                        rdy_q      <= 1'b0;
                        state      <= EXEC;
                    end else begin
                        rdy_q <= 1'b1;
                        state <= IDLE;
                    end
`else
                    rdy_q <= 1'b1;
                    state <= IDLE;
`endif
                end
                default: begin
                    rdy_q <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU stand-in.
// Directed vectors; expected results hand-computed.
`ifndef ALU_NOP
`define ALU_NOP 6'h00
`define ALU_ADD 6'h01
`define ALU_SUB 6'h02
`define ALU_AND 6'h03
`define ALU_OR  6'h04
`define ALU_XOR 6'h05
`define ALU_NOT 6'h06
`define ALU_INC 6'h07
`define ALU_DEC 6'h08
`define ALU_SHL 6'h09
`define ALU_SHR 6'h0A
`define ALU_MUL 6'h0B
`define ALU_DIV 6'h0C
`define ALU_MOD 6'h0D
`define ALU_CMP 6'h0E
`define ALU_TST 6'h0F
`define ALU_MOV 6'h10
`endif

module tb_alu_issue_ctrl;
    localparam int REG_AW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.REG_AW(REG_AW)) ifc ();

    logic [15:0]       alu_A, alu_B, alu_Result, dbg_data;
    logic [5:0]        alu_opcode;
    logic              alu_enable;
    logic [3:0]        alu_flags, flag_reg;
    logic [REG_AW-1:0] dbg_addr;

    alu_issue_ctrl #(.NREGS(8), .REG_AW(REG_AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (ifc),
        .alu_A      (alu_A),
        .alu_B      (alu_B),
        .alu_opcode (alu_opcode),
        .alu_enable (alu_enable),
        .alu_Result (alu_Result),
        .alu_flags  (alu_flags),
        .flag_reg   (flag_reg),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    // Stand-in for the existing combinational ALU.
    logic [16:0] am_w;
    logic [15:0] am_r;
    logic        am_c, am_v;
    always_comb begin
        am_w = 17'h0;
        am_r = 16'h0;
        am_c = 1'b0;
        am_v = 1'b0;
        case (alu_opcode)
            `ALU_ADD: begin
                am_w = {1'b0, alu_A} + {1'b0, alu_B};
                am_r = am_w[15:0];
                am_c = am_w[16];
                am_v = (alu_A[15] == alu_B[15]) && (am_r[15] != alu_A[15]);
            end
            `ALU_SUB, `ALU_CMP: begin
                am_r = alu_A - alu_B;
                am_c = alu_A < alu_B;
                am_v = (alu_A[15] != alu_B[15]) && (am_r[15] != alu_A[15]);
            end
            `ALU_AND, `ALU_TST: am_r = alu_A & alu_B;
            `ALU_OR:  am_r = alu_A | alu_B;
            `ALU_XOR: am_r = alu_A ^ alu_B;
            `ALU_NOT: am_r = ~alu_A;
            `ALU_INC: begin
                am_r = alu_A + 16'h1;
                am_c = alu_A == 16'hFFFF;
            end
            `ALU_DEC: am_r = alu_A - 16'h1;
            `ALU_SHL: am_r = alu_A << alu_B[3:0];
            `ALU_SHR: am_r = alu_A >> alu_B[3:0];
            `ALU_MUL: am_r = alu_A * alu_B;
            `ALU_DIV: am_r = (alu_B == 16'h0) ? 16'hFFFF : alu_A / alu_B;
            `ALU_MOD: am_r = (alu_B == 16'h0) ? 16'hFFFF : alu_A % alu_B;
            `ALU_MOV: am_r = alu_B;
            default:  am_r = 16'h0;
        endcase
        alu_Result = am_r;
        alu_flags  = {am_r == 16'h0, am_r[15], am_c, am_v};
    end

    typedef struct {
        logic [15:0] res;
        logic        err;
        int          hs;
    } exp_t;

    exp_t sbq[$];
    int   done_cyc[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every retire pops one expected entry.
    always @(negedge clk) begin
        if (rst_n && ifc.done) begin
            done_cyc.push_back(cyc);
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 expected 0");
            end else begin
                mon_e = sbq.pop_front();
                chk("done_result", ifc.done_result, mon_e.res);
                chk("err_div0", ifc.err_div0, mon_e.err);
                chk("latency", cyc - mon_e.hs, 2);
            end
        end
    end

    task automatic issue(input logic [5:0] op, input logic [2:0] d,
                         input logic [2:0] sa, input logic [2:0] sb,
                         input logic ui, input logic [15:0] imm,
                         input logic [15:0] er, input logic ee);
        exp_t e;
        int   k;
        @(negedge clk);
        ifc.req_valid   = 1'b1;
        ifc.req_opcode  = op;
        ifc.req_dst     = d;
        ifc.req_src_a   = sa;
        ifc.req_src_b   = sb;
        ifc.req_use_imm = ui;
        ifc.req_imm     = imm;
        k = 0;
        while (!ifc.req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!ifc.req_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got req_ready=0 expected 1");
            ifc.req_valid = 1'b0;
            return;
        end
        e.res = er;
        e.err = ee;
        e.hs  = cyc;
        sbq.push_back(e);
        @(posedge clk);
        #1 ifc.req_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sbq.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (sbq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0",
                     sbq.size());
            sbq.delete();
        end
        @(negedge clk);
    endtask

    task automatic rd(input logic [2:0] a, input logic [15:0] exp,
                      input string nm);
        dbg_addr = a;
        #1;
        chk(nm, dbg_data, exp);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.req_valid   = 1'b0;
        ifc.req_opcode  = `ALU_NOP;
        ifc.req_dst     = '0;
        ifc.req_src_a   = '0;
        ifc.req_src_b   = '0;
        ifc.req_use_imm = 1'b0;
        ifc.req_imm     = 16'h0;
        dbg_addr        = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_ready", ifc.req_ready, 1);
        chk("rst_done", ifc.done, 0);
        chk("rst_flags", flag_reg, 4'h0);
        chk("rst_enable", alu_enable, 0);
        chk("rst_opcode", alu_opcode, `ALU_NOP);
        chk("rst_alu_a", alu_A, 16'h0);
        rd(3'd1, 16'h0, "rst_r1");

        // R0 and immediates
        issue(`ALU_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0005, 16'h0005, 1'b0);
        drain();
        rd(3'd1, 16'h0005, "r1_imm5");
        chk("flags_imm5", flag_reg, 4'b0000);
        issue(`ALU_ADD, 3'd0, 3'd0, 3'd0, 1'b1, 16'h0007, 16'h0007, 1'b0);
        drain();
        rd(3'd0, 16'h0000, "r0_zero");

        // Carry and zero
        issue(`ALU_ADD, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0009, 16'h0009, 1'b0);
        issue(`ALU_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
        drain();
        chk("flags_neg", flag_reg, 4'b0100);
        issue(`ALU_ADD, 3'd2, 3'd1, 3'd0, 1'b1, 16'h0001, 16'h0000, 1'b0);
        drain();
        rd(3'd2, 16'h0000, "r2_wrap");
        chk("flags_zc", flag_reg, 4'b1010);

        // Compare, NOP and unknown opcode
        issue(`ALU_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0005, 16'h0005, 1'b0);
        issue(`ALU_ADD, 3'd3, 3'd0, 3'd0, 1'b1, 16'h0033, 16'h0033, 1'b0);
        issue(`ALU_CMP, 3'd3, 3'd1, 3'd0, 1'b1, 16'h0005, 16'h0000, 1'b0);
        drain();
        chk("flags_cmp", flag_reg, 4'b1000);
        rd(3'd3, 16'h0033, "r3_cmp");
        issue(`ALU_NOP, 3'd3, 3'd1, 3'd0, 1'b1, 16'h0001, 16'h0000, 1'b0);
        drain();
        chk("flags_nop", flag_reg, 4'b1000);
        rd(3'd3, 16'h0033, "r3_nop");
        issue(6'h3F, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0077, 16'h0000, 1'b0);
        drain();
        rd(3'd1, 16'h0005, "r1_unknown");
        chk("flags_unknown", flag_reg, 4'b1000);

        // Divide by zero, normal divide, register operand
        issue(`ALU_DIV, 3'd4, 3'd1, 3'd0, 1'b1, 16'h0000, 16'hFFFF, 1'b1);
        drain();
        rd(3'd4, 16'h0000, "r4_div0");
        chk("flags_div0", flag_reg, 4'b1000);
        issue(`ALU_DIV, 3'd4, 3'd1, 3'd0, 1'b1, 16'h0002, 16'h0002, 1'b0);
        drain();
        rd(3'd4, 16'h0002, "r4_div");
        chk("flags_div", flag_reg, 4'b0000);
        issue(`ALU_SUB, 3'd5, 3'd4, 3'd1, 1'b0, 16'h0000, 16'hFFFD, 1'b0);
        drain();
        rd(3'd5, 16'hFFFD, "r5_sub");
        chk("flags_sub", flag_reg, 4'b0110);
        issue(`ALU_MOD, 3'd6, 3'd1, 3'd0, 1'b0, 16'h0000, 16'hFFFF, 1'b1);
        drain();
        rd(3'd6, 16'h0000, "r6_mod0");
        chk("flags_mod0", flag_reg, 4'b0110);

        // Reset while in EXEC
        @(negedge clk);
        ifc.req_valid   = 1'b1;
        ifc.req_opcode  = `ALU_ADD;
        ifc.req_dst     = 3'd3;
        ifc.req_src_a   = 3'd1;
        ifc.req_use_imm = 1'b1;
        ifc.req_imm     = 16'h0001;
        @(posedge clk);
        #1 ifc.req_valid = 1'b0;
        chk("exec_enable", alu_enable, 1);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_done", ifc.done, 0);
        chk("abort_ready", ifc.req_ready, 1);
        rd(3'd3, 16'h0000, "abort_r3");
        rd(3'd1, 16'h0000, "abort_r1");
        chk("abort_flags", flag_reg, 4'h0);

        // Back-to-back dependent pair
        issue(`ALU_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0004, 16'h0004, 1'b0);
        drain();
        done_cyc.delete();
        issue(`ALU_INC, 3'd1, 3'd1, 3'd0, 1'b1, 16'h0000, 16'h0005, 1'b0);
        issue(`ALU_ADD, 3'd2, 3'd1, 3'd1, 1'b0, 16'h0000, 16'h000A, 1'b0);
        drain();
        rd(3'd1, 16'h0005, "b2b_r1");
        rd(3'd2, 16'h000A, "b2b_r2");
        if (done_cyc.size() == 2) begin
`ifdef ALU_ISSUE_BYPASS_EN
            chk("b2b_spacing", done_cyc[1] - done_cyc[0], 2);
`else
            chk("b2b_spacing", done_cyc[1] - done_cyc[0], 3);
`endif
        end else begin
            n_cmp++;
            n_bad++;
            $display("FAIL b2b_count: got %0d expected 2", done_cyc.size());
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Initiator side of the ALU datapath: accepts one instruction per handshake and reads its operands from a small internal register file. It drives the combinational ALU (A, B, opcode, enable), captures Result and flags, then writes back to the register file and an architectural flag register. It sits between the decode stage and the existing ALU and reuses the shared `ALU_*` opcode definitions file.

Parameters:
NREGS, 8, number of 16-bit registers; R0 is hardwired to zero.
REG_AW, 3, register address width; must equal clog2(NREGS).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  instruction request valid
req_ready  output  1  block can accept a request this cycle
req_opcode  input  6  `ALU_*` opcode
req_dst  input  REG_AW  destination register
req_src_a  input  REG_AW  operand A register
req_src_b  input  REG_AW  operand B register
req_use_imm  input  1  1: B = req_imm; 0: B = rf[req_src_b]
req_imm  input  16  immediate operand
alu_A  output  16  to ALU A
alu_B  output  16  to ALU B
alu_opcode  output  6  to ALU opcode
alu_enable  output  1  to ALU enable
alu_Result  input  16  from ALU Result
alu_flags  input  4  from ALU flags {zero, neg, carry, overflow}
done  output  1  one-cycle pulse: instruction retired
done_result  output  16  result of the retiring instruction
err_div0  output  1  one-cycle pulse with done: DIV/MOD with B == 0
flag_reg  output  4  architectural flags, same bit order as alu_flags
dbg_addr  input  REG_AW  debug register read address
dbg_data  output  16  combinational rf[dbg_addr]; R0 reads 0

Behaviour:
- Reset: asynchronous on rst_n low. State = IDLE; all registers, flag_reg, done, done_result, err_div0, alu_A, alu_B and alu_enable = 0. alu_opcode = `ALU_NOP.
- Reset mid-instruction aborts it: no writeback and no done pulse.
- FSM has three states: IDLE, EXEC, WB.
- IDLE: req_ready = 1. On req_valid: latch opcode and dst. Latch A = rf[src_a] and B = (use_imm ? imm : rf[src_b]). Go to EXEC.
- EXEC: req_ready = 0 and alu_enable = 1. alu_A, alu_B and alu_opcode come from the latched operands. At the clock edge, capture alu_Result and alu_flags. Go to WB.
- WB: done = 1 and done_result = captured result. Then go to IDLE.
- WB writeback rules:
  - rf[dst] is written unless the opcode is `ALU_CMP, `ALU_TST or `ALU_NOP, or dst == 0.
  - flag_reg is updated unless the opcode is `ALU_NOP.
- Latency: handshake edge to done high is 2 cycles. Throughput is 1 instruction per 3 cycles without the optional feature.
- alu_enable = 0 outside EXEC. alu_A, alu_B and alu_opcode hold their last values outside EXEC.
- R0 always reads 0, whether as an operand or through dbg_data. Writes to R0 are discarded, but flags still update.
- Divide by zero: for `ALU_DIV or `ALU_MOD with latched B == 0, suppress both the register write and the flag update. done_result = 0xFFFF. err_div0 pulses together with done.
- An unknown opcode is treated as `ALU_NOP: done pulses, nothing is written.
- req_valid while req_ready = 0 is ignored. The requester must hold the request until it is accepted.
- All register file reads are taken at the handshake edge. Later changes to the register file do not affect a latched instruction.

Optional Feature:
ALU_ISSUE_BYPASS_EN
- Defined: req_ready = 1 in WB as well as IDLE. A request accepted in WB goes directly to EXEC, giving 1 instruction per 2 cycles.
- Defined: an operand read in WB whose source register equals the dst being written in that WB cycle receives the new value (forwarded), not the stale register file value.
- Undefined: req_ready = 0 in WB, and the behaviour is exactly as described above.

Test Plan:
- R0 and immediates: ADD dst=1, src_a=0, use_imm, imm=5 -> done 2 cycles after handshake, done_result=5, dbg rf[1]=5, flag_reg=0000. ADD dst=0, imm=7 -> dbg rf[0] still reads 0.
- Carry and zero: load R1=0xFFFF, then ADD dst=2, R1 + imm 1 -> rf[2]=0, flag_reg zero=1 and carry=1.
- Compare: CMP R1=5 with imm 5 -> flag_reg zero=1, rf[dst] unchanged. Follow with NOP -> flag_reg still has zero=1.
- Divide by zero: DIV R1 by imm 0 -> done with err_div0=1, done_result=0xFFFF, rf[dst] and flag_reg unchanged.
- Reset mid-instruction: assert rst_n=0 during EXEC of ADD dst=3 -> no done pulse, rf[3]=0, req_ready=1 after release.
- With ALU_ISSUE_BYPASS_EN: INC dst=1 then ADD dst=2, R1 + R1, issued back-to-back with R1 initially 4 -> second request accepted in WB, rf[2]=10, done pulses 2 cycles apart.
